// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with a one-word holding register,
// so consecutive words stream with no idle gap between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic [15:0]      frame_cnt
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [WIDTH-1:0] hold_q, hold_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [15:0]      frame_nxt;
  logic             accept, at_last;
  logic [WIDTH-1:0] shifted;

  assign load_ready = !rst && !hold_valid;
  assign accept     = load_valid && load_ready;
  assign at_last    = (cnt == CW'(WIDTH-1));
  assign shifted    = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_q;
    hold_nxt       = hold_q;
    hold_valid_nxt = hold_valid;
    cnt_nxt        = cnt;
    frame_nxt      = frame_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shift_nxt = shifted;
          cnt_nxt   = cnt + 1'b1;
          if (accept) begin
            hold_nxt       = din;
            hold_valid_nxt = 1'b1;
          end
        end else begin
          frame_nxt = frame_cnt + 16'd1;
          // Held word has priority; load_ready is low whenever hold is full,
          // so a direct load can only happen with hold empty.
          if (hold_valid) begin
            shift_nxt      = hold_q;
            hold_valid_nxt = 1'b0;
            cnt_nxt        = '0;
          end else if (accept) begin
            shift_nxt = din;
            cnt_nxt   = '0;
          end else begin
            shift_nxt = shifted;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      hold_q     <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      cnt        <= cnt_nxt;
      frame_cnt  <= frame_nxt;
    end
  end

  // Outputs decode from registered state only.
  assign ser_valid = (state == SHIFT);
  assign last_bit  = (state == SHIFT) && at_last;
  assign ser_out   = (state == SHIFT) ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                      : IDLE_BIT;
endmodule

// File: tb/tb_piso_serializer.sv
// Drives two serializer configurations with directed and random traffic and
// compares every output each cycle against a bit-queue reference model.
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] din = '0;

  logic       rdy0, so0, sv0, lb0;
  logic [15:0] fc0;
  logic       rdy1, so1, sv1, lb1;
  logic [15:0] fc1;

  int n_chk = 0;
  int n_fail = 0;
  logic acc0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(rdy0), .ser_out(so0), .ser_valid(sv0), .last_bit(lb0), .frame_cnt(fc0));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din[3:0]), .load_valid(load_valid),
    .load_ready(rdy1), .ser_out(so1), .ser_valid(sv1), .last_bit(lb1), .frame_cnt(fc1));

  // Model: queue of bits still to appear on ser_out (front = current bit).
  // Up to W bits means one word in flight; more means a word is held.
  int W     [2] = '{8, 4};
  bit MSBF  [2] = '{1'b1, 1'b0};
  bit IDLEB [2] = '{1'b0, 1'b1};
  bit bq    [2][$];
  int frames[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic lv, input logic [7:0] d, input logic r);
    logic rdy [2];
    int   sz;
    load_valid = lv;
    din        = d;
    rst        = r;
    for (int i = 0; i < 2; i++) rdy[i] = !r && (bq[i].size() <= W[i]);
    acc0 = lv && rdy[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        bq[i].delete();
        frames[i] = 0;
      end else begin
        sz = bq[i].size();
        if (sz > 0) begin
          if (sz == 1 || sz == W[i] + 1) frames[i]++;
          void'(bq[i].pop_front());
        end
        if (lv && rdy[i])
          for (int b = 0; b < W[i]; b++)
            bq[i].push_back(MSBF[i] ? d[W[i]-1-b] : d[b]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic e_sv, e_so, e_lb, e_rdy;
      sz    = bq[i].size();
      e_sv  = (sz > 0);
      e_so  = (sz > 0) ? bq[i][0] : IDLEB[i];
      e_lb  = (sz == 1) || (sz == W[i] + 1);
      e_rdy = !rst && (sz <= W[i]);
      chk($sformatf("ser_valid%0d", i), 32'(i == 0 ? sv0 : sv1), 32'(e_sv));
      chk($sformatf("ser_out%0d", i),   32'(i == 0 ? so0 : so1), 32'(e_so));
      chk($sformatf("last_bit%0d", i),  32'(i == 0 ? lb0 : lb1), 32'(e_lb));
      chk($sformatf("load_ready%0d", i), 32'(i == 0 ? rdy0 : rdy1), 32'(e_rdy));
      chk($sformatf("frame_cnt%0d", i), 32'(i == 0 ? fc0 : fc1), 32'(frames[i] & 16'hFFFF));
    end
  endtask

  logic [7:0] words [3] = '{8'hFF, 8'h00, 8'hAA};

  initial begin
    int idx, guard;
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Single word after reset release, then drain to idle.
    step(1'b1, 8'hE7, 1'b0);
    repeat (10) step(1'b0, 8'h00, 1'b0);

    // Back-to-back words with load_valid held high.
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 100) begin
      step(1'b1, words[idx], 1'b0);
      if (acc0) idx++;
      guard++;
    end
    chk("b2b_accepts", 32'(idx), 32'd3);
    repeat (30) step(1'b0, 8'h00, 1'b0);

    // Accept exactly on the last-bit cycle with hold empty.
    step(1'b1, 8'h0F, 1'b0);
    guard = 0;
    while (bq[0].size() != 1 && guard < 20) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("reached_last_bit", 32'(bq[0].size()), 32'd1);
    step(1'b1, 8'h81, 1'b0);
    repeat (12) step(1'b0, 8'h00, 1'b0);

    // Reset mid-word with a held word pending.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 199) == 0));
    repeat (20) step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
